// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and control bundle for mem_port_arbiter.
// master: requesters + memory side; slave: the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic          hold;
    logic          busy;
    logic          d_req;
    logic          f_req;
    logic          x_req;
    logic          d_we;
    logic          x_we;
    logic [AW-1:0] d_addr;
    logic [AW-1:0] f_addr;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] x_wdata;
    logic          d_gnt;
    logic          f_gnt;
    logic          x_gnt;
    logic          d_rvalid;
    logic          f_rvalid;
    logic          x_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output hold, d_req, f_req, x_req, d_we, x_we,
        output d_addr, f_addr, x_addr, d_wdata, x_wdata,
        output mem_rdata,
        input  busy, d_gnt, f_gnt, x_gnt,
        input  d_rvalid, f_rvalid, x_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  hold, d_req, f_req, x_req, d_we, x_we,
        input  d_addr, f_addr, x_addr, d_wdata, x_wdata,
        input  mem_rdata,
        output busy, d_gnt, f_gnt, x_gnt,
        output d_rvalid, f_rvalid, x_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer/arbiter for D, F and X requesters.
// Ports: clk, rst (async active-low), bus (slave modport): requests,
// grants, rvalids, shared rdata, memory strobes, hold and busy.
module mem_port_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int STARVE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [2:0] AGE_MAX  = 3'd7;
    localparam logic [2:0] STARVE_C = 3'(STARVE);
    localparam logic [2:0] LAT_C    = 3'(MEM_LAT - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      id_q, id_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0][2:0] age_q, age_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      rvalid_q, rvalid_d;
    logic            busy_q, busy_d;

    // Bit 0 = D, bit 1 = F, bit 2 = X (also fixed priority order).
    logic [2:0] req;
    logic [2:0] aged;
    logic [2:0] sel;

    assign req = {bus.x_req, bus.f_req, bus.d_req};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            aged[i] = req[i] && (age_q[i] >= STARVE_C);
        end
    end

    // Aged requesters outrank everyone; within a class D > F > X.
    always_comb begin
        sel = 3'b000;
        if (aged[0])      sel = 3'b001;
        else if (aged[1]) sel = 3'b010;
        else if (aged[2]) sel = 3'b100;
        else if (req[0])  sel = 3'b001;
        else if (req[1])  sel = 3'b010;
        else if (req[2])  sel = 3'b100;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        gnt_d       = 3'b000;
        rvalid_d    = 3'b000;
        case (state_q)
            IDLE: begin
                if (!bus.hold && (|req)) begin
                    state_d  = ACCESS;
                    id_d     = sel;
                    gnt_d    = sel;
                    mem_en_d = 1'b1;
                    unique case (1'b1)
                        sel[0]: begin
                            mem_we_d    = bus.d_we;
                            mem_addr_d  = bus.d_addr;
                            mem_wdata_d = bus.d_wdata;
                        end
                        sel[1]: begin
                            mem_addr_d  = bus.f_addr;
                        end
                        default: begin
                            mem_we_d    = bus.x_we;
                            mem_addr_d  = bus.x_addr;
                            mem_wdata_d = bus.x_wdata;
                        end
                    endcase
                end
            end
            ACCESS: begin
                // mem_we_q still holds the latched write flag here.
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_C;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d  = RESP;
                    rdata_d  = bus.mem_rdata;
                    rvalid_d = id_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // A dropped request always forgets its age, even mid-access.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            age_d[i] = age_q[i];
            if (!req[i]) begin
                age_d[i] = 3'd0;
            end else if (state_q == ACCESS) begin
                if (id_q[i]) begin
                    age_d[i] = 3'd0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            id_q        <= 3'b000;
            cnt_q       <= 3'd0;
            age_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.d_gnt     = gnt_q[0];
    assign bus.f_gnt     = gnt_q[1];
    assign bus.x_gnt     = gnt_q[2];
    assign bus.d_rvalid  = rvalid_q[0];
    assign bus.f_rvalid  = rvalid_q[1];
    assign bus.x_rvalid  = rvalid_q[2];
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE=2.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.AW(10), .DW(32)) bus();

    mem_port_arbiter #(
        .AW(10), .DW(32), .MEM_LAT(2), .STARVE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a 2-cycle read pipeline.
    logic [31:0] mem [0:1023];
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        p1 <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'h0;
        p2 <= p1;
    end
    assign bus.mem_rdata = p2;

    int passed = 0;
    int total  = 0;
    int n_fail = 0;
    int got[$];
    int exp_ord [9] = '{0, 0, 1, 2, 0, 1, 2, 0, 1};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.hold = 0;
        bus.d_req = 0; bus.f_req = 0; bus.x_req = 0;
        bus.d_we = 0;  bus.x_we = 0;
        bus.d_addr = 0; bus.f_addr = 0; bus.x_addr = 0;
        bus.d_wdata = 0; bus.x_wdata = 0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_gnt", {bus.d_gnt, bus.f_gnt, bus.x_gnt}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_addr", bus.mem_addr, 0);
        tick();
        rst = 1'b1;

        // D write 0xDEADBEEF to 0x10
        bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 10'h010; bus.d_wdata = 32'hDEADBEEF;
        tick();
        chk("dw_gnt", bus.d_gnt, 1);
        chk("dw_mem_we", bus.mem_we, 1);
        chk("dw_addr", bus.mem_addr, 10'h010);
        chk("dw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.d_req = 0; bus.d_we = 0;
        tick();
        chk("dw_idle", bus.busy, 0);

        // D read of 0x10, request in cycle 0
        bus.d_req = 1; bus.d_addr = 10'h010;
        tick();
        chk("dr_c1_en", bus.mem_en, 1);
        chk("dr_c1_gnt", bus.d_gnt, 1);
        chk("dr_c1_we", bus.mem_we, 0);
        bus.d_req = 0;
        tick();
        chk("dr_c2_en", bus.mem_en, 0);
        chk("dr_c2_busy", bus.busy, 1);
        tick();
        chk("dr_c3_rv", bus.d_rvalid, 0);
        tick();
        chk("dr_c4_rv", bus.d_rvalid, 1);
        chk("dr_c4_rdata", bus.rdata, 32'hDEADBEEF);
        tick();
        chk("dr_c5_busy", bus.busy, 0);
        chk("dr_c5_rv", bus.d_rvalid, 0);
        chk("dr_c5_hold", bus.rdata, 32'hDEADBEEF);

        // X write 0x12345678 to 0x3FF, then F read of 0x3FF
        bus.x_req = 1; bus.x_we = 1;
        bus.x_addr = 10'h3FF; bus.x_wdata = 32'h12345678;
        tick();
        chk("xw_gnt", bus.x_gnt, 1);
        chk("xw_we", bus.mem_we, 1);
        bus.x_req = 0; bus.x_we = 0;
        bus.f_req = 1; bus.f_addr = 10'h3FF;
        tick();
        chk("xw_c2_we", bus.mem_we, 0);
        chk("xw_c2_fgnt", bus.f_gnt, 0);
        tick();
        chk("fr_gnt", bus.f_gnt, 1);
        chk("fr_we", bus.mem_we, 0);
        bus.f_req = 0;
        tick();
        tick();
        tick();
        chk("fr_rv", bus.f_rvalid, 1);
        chk("fr_rdata", bus.rdata, 32'h12345678);
        tick();
        chk("fr_idle", bus.busy, 0);

        // hold raised during the WAIT of a D read, F pending
        bus.d_req = 1; bus.d_addr = 10'h010;
        tick();
        chk("hd_dgnt", bus.d_gnt, 1);
        bus.d_req = 0;
        bus.f_req = 1; bus.f_addr = 10'h010;
        tick();
        bus.hold = 1;
        tick();
        tick();
        chk("hd_drv", bus.d_rvalid, 1);
        chk("hd_rdata", bus.rdata, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hd_no_fgnt", bus.f_gnt, 0);
        end
        bus.hold = 0;
        tick();
        chk("hd_fgnt", bus.f_gnt, 1);
        bus.f_req = 0;
        tick();
        tick();
        tick();
        chk("hd_frv", bus.f_rvalid, 1);
        tick();

        // reset in the middle of WAIT
        bus.d_req = 1; bus.d_addr = 10'h3FF;
        tick();
        chk("rs_dgnt", bus.d_gnt, 1);
        bus.d_req = 0;
        bus.f_req = 1; bus.f_addr = 10'h010;
        tick();
        chk("rs_busy_pre", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs_busy", bus.busy, 0);
        chk("rs_en", bus.mem_en, 0);
        chk("rs_rdata", bus.rdata, 0);
        chk("rs_addr", bus.mem_addr, 0);
        tick();
        chk("rs_drv", bus.d_rvalid, 0);
        chk("rs_fgnt_low", bus.f_gnt, 0);
        #2;
        rst = 1'b1;
        tick();
        chk("rs_fgnt", bus.f_gnt, 1);
        chk("rs_faddr", bus.mem_addr, 10'h010);
        bus.f_req = 0;
        tick();
        chk("rs_drv2", bus.d_rvalid, 0);
        tick();
        tick();
        chk("rs_frv", bus.f_rvalid, 1);
        chk("rs_frdata", bus.rdata, 32'hDEADBEEF);
        tick();

        // F withdraws while D is served; its age must restart
        bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 10'h020; bus.d_wdata = 32'h1;
        bus.f_req = 1; bus.f_addr = 10'h010;
        tick();
        chk("wd_dgnt", bus.d_gnt, 1);
        chk("wd_fgnt1", bus.f_gnt, 0);
        bus.d_req = 0; bus.f_req = 0;
        tick();
        chk("wd_fgnt2", bus.f_gnt, 0);
        tick();
        chk("wd_fgnt3", bus.f_gnt, 0);
        chk("wd_idle", bus.busy, 0);
        bus.d_req = 1; bus.d_addr = 10'h021; bus.d_wdata = 32'h2;
        bus.f_req = 1;
        tick();
        chk("wd_g1_d", bus.d_gnt, 1);
        tick();
        tick();
        chk("wd_g2_d", bus.d_gnt, 1);
        chk("wd_g2_f", bus.f_gnt, 0);
        tick();
        tick();
        chk("wd_g3_f", bus.f_gnt, 1);
        bus.d_req = 0; bus.d_we = 0; bus.f_req = 0;
        tick();
        tick();
        tick();
        chk("wd_frv", bus.f_rvalid, 1);
        tick();

        // all three held high, STARVE=2
        bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 10'h030; bus.d_wdata = 32'hA;
        bus.x_req = 1; bus.x_we = 1;
        bus.x_addr = 10'h031; bus.x_wdata = 32'hB;
        bus.f_req = 1; bus.f_addr = 10'h010;
        for (int c = 0; c < 200 && got.size() < 9; c++) begin
            tick();
            if (bus.d_gnt) got.push_back(0);
            if (bus.f_gnt) got.push_back(1);
            if (bus.x_gnt) got.push_back(2);
        end
        bus.d_req = 0; bus.f_req = 0; bus.x_req = 0;
        bus.d_we = 0; bus.x_we = 0;
        chk("arb_count", got.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("arb_g%0d", i + 1),
                (i < got.size()) ? got[i] : -1, exp_ord[i]);
        end
        for (int c = 0; c < 10 && bus.busy; c++) tick();
        chk("arb_drain", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
